sram_addr_sequencer: RTL and testbench

- Multi-channel address/control sequencer that drives NUM_CH independent single-port SRAMs, such as the input/weight SRAM and the accumulation SRAM.
- Replaces the fixed increment-by-one instruction-bit scheme with burst descriptors: base, length, stride and direction. Adds pause, abort, done pulses and read-data-valid tracking.
- Sits between the core's control/instruction decode and the SRAM macros.

---
 rtl/sram_addr_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_sram_addr_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_addr_sequencer.sv
// Multi-channel SRAM address/control sequencer.
// Each channel runs an independent burst described by base address, access
// count, unsigned stride and direction. Bursts can be paused (level) or
// aborted (pulse), and signal completion with a one-cycle done pulse.
// Every output is registered; rd_valid tracks the 1-cycle SRAM read latency.
module sram_addr_sequencer #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        start,
  input  logic [NUM_CH-1:0]        wr_mode,
  input  logic [NUM_CH*ADDR_W-1:0] base_addr,
  input  logic [NUM_CH*LEN_W-1:0]  length,
  input  logic [NUM_CH*ADDR_W-1:0] stride,
  input  logic [NUM_CH-1:0]        pause,
  input  logic [NUM_CH-1:0]        abort,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  output logic [NUM_CH*ADDR_W-1:0] sram_addr,
  output logic [NUM_CH-1:0]        sram_cen,
  output logic [NUM_CH-1:0]        sram_wen,
  output logic [NUM_CH*DATA_W-1:0] sram_din,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH-1:0]        rd_valid
);

  // RUN covers the cycles in which accesses are being decided; FIN is the
  // single cycle after the last access is decided, during which the done
  // pulse is prepared and a new start may already be accepted.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch

    // Per-channel views of the packed input buses.
    logic              chStart;
    logic              chWrMode;
    logic [ADDR_W-1:0] chBase;
    logic [LEN_W-1:0]  chLength;
    logic [ADDR_W-1:0] chStride;
    logic              chPause;
    logic              chAbort;
    logic [DATA_W-1:0] chWrData;

    assign chStart  = start[ch];
    assign chWrMode = wr_mode[ch];
    assign chBase   = base_addr[ch*ADDR_W +: ADDR_W];
    assign chLength = length[ch*LEN_W +: LEN_W];
    assign chStride = stride[ch*ADDR_W +: ADDR_W];
    assign chPause  = pause[ch];
    assign chAbort  = abort[ch];
    assign chWrData = wr_data[ch*DATA_W +: DATA_W];

    // Burst descriptor and progress state.
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] curAddr_q, curAddr_d;
    logic [ADDR_W-1:0] strideVal_q, strideVal_d;
    logic [LEN_W-1:0]  lenVal_q, lenVal_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic              wrMode_q, wrMode_d;

    // Registered SRAM-facing and status outputs.
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cen_q, cen_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rdValid_q, rdValid_d;

    // A start is only honoured when no burst is in flight (IDLE or FIN).
    logic acceptStart;
    assign acceptStart = chStart && (state_q != RUN);

    // Next-state and next-output decode for one channel.
    always_comb begin
      state_d     = state_q;
      curAddr_d   = curAddr_q;
      strideVal_d = strideVal_q;
      lenVal_d    = lenVal_q;
      count_d     = count_q;
      wrMode_d    = wrMode_q;
      addr_d      = addr_q;
      cen_d       = 1'b1;
      wen_d       = 1'b1;
      din_d       = din_q;
      done_d      = 1'b0;
      rdValid_d   = ~cen_q & wen_q;

      case (state_q)
        IDLE: begin
          if (acceptStart) begin
            curAddr_d   = chBase;
            strideVal_d = chStride;
            lenVal_d    = chLength;
            wrMode_d    = chWrMode;
            count_d     = '0;
            state_d     = (chLength == '0) ? FIN : RUN;
          end
        end

        RUN: begin
          if (chAbort) begin
            state_d = IDLE;
          end else if (!chPause) begin
            addr_d    = curAddr_q;
            cen_d     = 1'b0;
            wen_d     = ~wrMode_q;
            if (wrMode_q) begin
              din_d = chWrData;
            end
            curAddr_d = curAddr_q + strideVal_q;
            count_d   = count_q + LEN_W'(1);
            if (count_q + LEN_W'(1) == lenVal_q) begin
              state_d = FIN;
            end
          end
        end

        FIN: begin
          done_d  = 1'b1;
          state_d = IDLE;
          if (acceptStart) begin
            curAddr_d   = chBase;
            strideVal_d = chStride;
            lenVal_d    = chLength;
            wrMode_d    = chWrMode;
            count_d     = '0;
            state_d     = (chLength == '0) ? FIN : RUN;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase

      busy_d = (state_d == RUN);
    end

    // State and output registers; reset drops any burst without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q     <= IDLE;
        curAddr_q   <= '0;
        strideVal_q <= '0;
        lenVal_q    <= '0;
        count_q     <= '0;
        wrMode_q    <= 1'b0;
        addr_q      <= '0;
        cen_q       <= 1'b1;
        wen_q       <= 1'b1;
        din_q       <= '0;
        busy_q      <= 1'b0;
        done_q      <= 1'b0;
        rdValid_q   <= 1'b0;
      end else begin
        state_q     <= state_d;
        curAddr_q   <= curAddr_d;
        strideVal_q <= strideVal_d;
        lenVal_q    <= lenVal_d;
        count_q     <= count_d;
        wrMode_q    <= wrMode_d;
        addr_q      <= addr_d;
        cen_q       <= cen_d;
        wen_q       <= wen_d;
        din_q       <= din_d;
        busy_q      <= busy_d;
        done_q      <= done_d;
        rdValid_q   <= rdValid_d;
      end
    end

    assign sram_addr[ch*ADDR_W +: ADDR_W] = addr_q;
    assign sram_cen[ch]                   = cen_q;
    assign sram_wen[ch]                   = wen_q;
    assign sram_din[ch*DATA_W +: DATA_W]  = din_q;
    assign busy[ch]                       = busy_q;
    assign done[ch]                       = done_q;
    assign rd_valid[ch]                   = rdValid_q;

  end : g_ch

endmodule

// File: tb/tb_sram_addr_sequencer.sv
// Directed testbench for sram_addr_sequencer with hand-computed expectations.
module tb_sram_addr_sequencer;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 12;

  logic                     clk;
  logic                     reset;
  logic [NUM_CH-1:0]        start;
  logic [NUM_CH-1:0]        wr_mode;
  logic [NUM_CH*ADDR_W-1:0] base_addr;
  logic [NUM_CH*LEN_W-1:0]  length;
  logic [NUM_CH*ADDR_W-1:0] stride;
  logic [NUM_CH-1:0]        pause;
  logic [NUM_CH-1:0]        abort;
  logic [NUM_CH*DATA_W-1:0] wr_data;
  logic [NUM_CH*ADDR_W-1:0] sram_addr;
  logic [NUM_CH-1:0]        sram_cen;
  logic [NUM_CH-1:0]        sram_wen;
  logic [NUM_CH*DATA_W-1:0] sram_din;
  logic [NUM_CH-1:0]        busy;
  logic [NUM_CH-1:0]        done;
  logic [NUM_CH-1:0]        rd_valid;

  int checkCount = 0;
  int errorCount = 0;

  sram_addr_sequencer #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .wr_mode(wr_mode),
    .base_addr(base_addr), .length(length), .stride(stride),
    .pause(pause), .abort(abort), .wr_data(wr_data),
    .sram_addr(sram_addr), .sram_cen(sram_cen), .sram_wen(sram_wen),
    .sram_din(sram_din), .busy(busy), .done(done), .rd_valid(rd_valid)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge so outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addrOf(input int ch);
    return 32'(sram_addr[ch*ADDR_W +: ADDR_W]);
  endfunction

  function automatic logic [31:0] dinOf(input int ch);
    return sram_din[ch*DATA_W +: DATA_W];
  endfunction

  // Load a burst descriptor and raise start for one channel, no clock.
  task automatic setupBurst(input int ch, input logic wr, input int base, input int len, input int str);
    start[ch]                       = 1'b1;
    wr_mode[ch]                     = wr;
    base_addr[ch*ADDR_W +: ADDR_W]  = ADDR_W'(base);
    length[ch*LEN_W +: LEN_W]       = LEN_W'(len);
    stride[ch*ADDR_W +: ADDR_W]     = ADDR_W'(str);
  endtask

  // One-cycle start pulse on a single channel; returns just after the start edge.
  task automatic applyStimulus(input int ch, input logic wr, input int base, input int len, input int str);
    setupBurst(ch, wr, base, len, str);
    tick();
    start[ch] = 1'b0;
  endtask

  initial begin
    int expWrap [4];
    expWrap = '{2040, 2043, 2046, 1};

    reset     = 1'b1;
    start     = '0;
    wr_mode   = '0;
    base_addr = '0;
    length    = '0;
    stride    = '0;
    pause     = '0;
    abort     = '0;
    wr_data   = '0;

    // Reset values
    #12;
    checkOutput("rst_addr", 32'(sram_addr), 32'd0);
    checkOutput("rst_cen", 32'(sram_cen), 32'd3);
    checkOutput("rst_wen", 32'(sram_wen), 32'd3);
    checkOutput("rst_din0", dinOf(0), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rdv", 32'(rd_valid), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Channel 0 read: base 5, len 4, stride 1
    applyStimulus(0, 1'b0, 5, 4, 1);
    checkOutput("rd_busy_start", 32'(busy[0]), 32'd1);
    checkOutput("rd_cen_start", 32'(sram_cen[0]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("rd_addr", addrOf(0), 32'(5 + k));
      checkOutput("rd_cen", 32'(sram_cen[0]), 32'd0);
      checkOutput("rd_wen", 32'(sram_wen[0]), 32'd1);
      checkOutput("rd_busy", 32'(busy[0]), (k < 3) ? 32'd1 : 32'd0);
      checkOutput("rd_rdv", 32'(rd_valid[0]), (k > 0) ? 32'd1 : 32'd0);
      checkOutput("rd_done_early", 32'(done[0]), 32'd0);
    end
    tick();
    checkOutput("rd_done", 32'(done[0]), 32'd1);
    checkOutput("rd_rdv_last", 32'(rd_valid[0]), 32'd1);
    checkOutput("rd_cen_fin", 32'(sram_cen[0]), 32'd1);
    tick();
    checkOutput("rd_done_clear", 32'(done[0]), 32'd0);
    checkOutput("rd_rdv_clear", 32'(rd_valid[0]), 32'd0);
    checkOutput("rd_addr_hold", addrOf(0), 32'd8);

    // Channel 1 write with address wrap at 2048
    applyStimulus(1, 1'b1, 2040, 4, 3);
    for (int k = 0; k < 4; k++) begin
      wr_data[DATA_W +: DATA_W] = 32'h1000 + 32'(k * 17);
      tick();
      checkOutput("wr_addr", addrOf(1), 32'(expWrap[k]));
      checkOutput("wr_cen", 32'(sram_cen[1]), 32'd0);
      checkOutput("wr_wen", 32'(sram_wen[1]), 32'd0);
      checkOutput("wr_din", dinOf(1), 32'h1000 + 32'(k * 17));
      checkOutput("wr_rdv", 32'(rd_valid[1]), 32'd0);
    end
    wr_data[DATA_W +: DATA_W] = 32'hDEAD;
    tick();
    checkOutput("wr_done", 32'(done[1]), 32'd1);
    checkOutput("wr_din_hold", dinOf(1), 32'h1000 + 32'd51);
    checkOutput("wr_wen_fin", 32'(sram_wen[1]), 32'd1);
    checkOutput("wr_ch0_idle", 32'(sram_cen[0]), 32'd1);
    tick();

    // Pause: channel 0 read, base 0, len 3, pause two cycles after first access
    applyStimulus(0, 1'b0, 0, 3, 1);
    tick();
    checkOutput("pz_addr0", addrOf(0), 32'd0);
    checkOutput("pz_cen0", 32'(sram_cen[0]), 32'd0);
    pause[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("pz_hold_cen", 32'(sram_cen[0]), 32'd1);
      checkOutput("pz_hold_addr", addrOf(0), 32'd0);
      checkOutput("pz_hold_busy", 32'(busy[0]), 32'd1);
    end
    pause[0] = 1'b0;
    tick();
    checkOutput("pz_addr1", addrOf(0), 32'd1);
    checkOutput("pz_cen1", 32'(sram_cen[0]), 32'd0);
    tick();
    checkOutput("pz_addr2", addrOf(0), 32'd2);
    checkOutput("pz_done_early", 32'(done[0]), 32'd0);
    tick();
    checkOutput("pz_done", 32'(done[0]), 32'd1);
    tick();

    // Zero-length burst
    applyStimulus(0, 1'b0, 33, 0, 1);
    checkOutput("z_busy", 32'(busy[0]), 32'd0);
    checkOutput("z_cen", 32'(sram_cen[0]), 32'd1);
    checkOutput("z_done_early", 32'(done[0]), 32'd0);
    tick();
    checkOutput("z_done", 32'(done[0]), 32'd1);
    checkOutput("z_cen_fin", 32'(sram_cen[0]), 32'd1);
    tick();
    checkOutput("z_done_clear", 32'(done[0]), 32'd0);

    // Start while busy is ignored
    applyStimulus(0, 1'b0, 10, 3, 2);
    tick();
    checkOutput("sb_addr0", addrOf(0), 32'd10);
    applyStimulus(0, 1'b0, 100, 1, 1);
    checkOutput("sb_addr1", addrOf(0), 32'd12);
    tick();
    checkOutput("sb_addr2", addrOf(0), 32'd14);
    tick();
    checkOutput("sb_done", 32'(done[0]), 32'd1);
    tick();
    checkOutput("sb_idle_cen", 32'(sram_cen[0]), 32'd1);
    checkOutput("sb_idle_addr", addrOf(0), 32'd14);
    checkOutput("sb_done_clear", 32'(done[0]), 32'd0);

    // Abort after two of five accesses
    applyStimulus(0, 1'b0, 20, 5, 1);
    tick();
    checkOutput("ab_addr0", addrOf(0), 32'd20);
    tick();
    checkOutput("ab_addr1", addrOf(0), 32'd21);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    checkOutput("ab_cen", 32'(sram_cen[0]), 32'd1);
    checkOutput("ab_busy", 32'(busy[0]), 32'd0);
    checkOutput("ab_rdv", 32'(rd_valid[0]), 32'd1);
    checkOutput("ab_done", 32'(done[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("ab_no_done", 32'(done[0]), 32'd0);
      checkOutput("ab_no_cen", 32'(sram_cen[0]), 32'd1);
    end

    // Asynchronous reset mid-burst
    applyStimulus(1, 1'b1, 50, 6, 1);
    wr_data[DATA_W +: DATA_W] = 32'h77;
    tick();
    tick();
    checkOutput("rs_addr_pre", addrOf(1), 32'd51);
    reset = 1'b1;
    #1;
    checkOutput("rs_addr", 32'(sram_addr), 32'd0);
    checkOutput("rs_cen", 32'(sram_cen), 32'd3);
    checkOutput("rs_wen", 32'(sram_wen), 32'd3);
    checkOutput("rs_din1", dinOf(1), 32'd0);
    checkOutput("rs_busy", 32'(busy), 32'd0);
    checkOutput("rs_done", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("rs_no_done", 32'(done), 32'd0);
    applyStimulus(1, 1'b0, 7, 2, 5);
    tick();
    checkOutput("rs_new_addr0", addrOf(1), 32'd7);
    checkOutput("rs_new_wen", 32'(sram_wen[1]), 32'd1);
    tick();
    checkOutput("rs_new_addr1", addrOf(1), 32'd12);
    tick();
    checkOutput("rs_new_done", 32'(done[1]), 32'd1);
    tick();

    // Both channels started together with different strides
    setupBurst(0, 1'b0, 100, 3, 4);
    setupBurst(1, 1'b0, 200, 3, 7);
    tick();
    start = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("cc_addr0", addrOf(0), 32'(100 + 4 * k));
      checkOutput("cc_addr1", addrOf(1), 32'(200 + 7 * k));
      checkOutput("cc_cen", 32'(sram_cen), 32'd0);
    end
    tick();
    checkOutput("cc_done", 32'(done), 32'd3);
    tick();

    // Back-to-back: channel 0 restarted in its FIN cycle
    applyStimulus(0, 1'b0, 300, 2, 1);
    tick();
    checkOutput("bb_addr0", addrOf(0), 32'd300);
    tick();
    checkOutput("bb_addr1", addrOf(0), 32'd301);
    applyStimulus(0, 1'b0, 400, 2, 1);
    checkOutput("bb_done1", 32'(done[0]), 32'd1);
    checkOutput("bb_gap_cen", 32'(sram_cen[0]), 32'd1);
    tick();
    checkOutput("bb_addr2", addrOf(0), 32'd400);
    checkOutput("bb_cen2", 32'(sram_cen[0]), 32'd0);
    checkOutput("bb_done_clear", 32'(done[0]), 32'd0);
    tick();
    checkOutput("bb_addr3", addrOf(0), 32'd401);
    tick();
    checkOutput("bb_done2", 32'(done[0]), 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
